// File: rtl/ifetch_unit_pkg.sv
// Shared encodings for the instruction-fetch stage: next-PC operation codes,
// reset PC default, NOP encoding and the fetch FSM state type.
package ctrl_encode_def;

    // Next-PC selection codes driven by the decoder
    localparam logic [2:0] NPC_PLUS4  = 3'b000;
    localparam logic [2:0] NPC_BRANCH = 3'b001;
    localparam logic [2:0] NPC_JUMP   = 3'b010;
    localparam logic [2:0] NPC_JALR   = 3'b100;

    // Default PC after reset
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    // Fetch FSM states
    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_FAULT = 2'd3
    } ifu_state_e;

endpackage

// File: rtl/ifetch_unit_npc.sv
// Combinational next-PC computation for the fetch stage.
// Build option IFU_MISALIGN_TRAP_EN: when defined the raw target is passed
// through and a misalignment flag is raised; otherwise the target is forced
// to a word boundary and the flag is tied low.
module ifu_npc
    import ctrl_encode_def::*;
(
    input  logic [31:0] pc_i,
    input  logic [2:0]  npc_op_i,
    input  logic [31:0] imm_i,
    input  logic [31:0] alu_res_i,
    output logic [31:0] pc_plus4_o,
    output logic [31:0] next_pc_o,
    output logic        misaligned_o
);

    logic [31:0] target;

    assign pc_plus4_o = pc_i + 32'd4;

    // Select the raw target; unknown encodings fall back to sequential flow
    always_comb begin
        target = pc_plus4_o;
        case (npc_op_i)
            NPC_BRANCH, NPC_JUMP: target = pc_i + imm_i;
            NPC_JALR:             target = {alu_res_i[31:1], 1'b0};
            default:              target = pc_plus4_o;
        endcase
    end

`ifdef IFU_MISALIGN_TRAP_EN
    assign next_pc_o    = target;
    assign misaligned_o = |target[1:0];
`else
    assign next_pc_o    = target & 32'hFFFF_FFFC;
    assign misaligned_o = 1'b0;
`endif

endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: PC register, instruction register, one outstanding
// instruction-memory request, response timeout, PC update on retire.
// Build option IFU_MISALIGN_TRAP_EN: misaligned next-PC traps into S_FAULT and
// raises ifu_fault; undefined, targets are word-aligned and ifu_fault is 0.
//
// Memory handshake: imem_req is held high with imem_addr stable until a rising
// edge samples imem_req && imem_gnt; that edge transfers the request. The
// response is a single imem_rvalid cycle, accepted only in S_WAIT (at the
// earliest one cycle after the grant), with no back-pressure.
module ifetch_unit
    import ctrl_encode_def::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned IMEM_TO  = 16
) (
    input  logic        clk,
    input  logic        rstn,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic        inst_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        retire,
    input  logic [2:0]  npc_op,
    input  logic [31:0] imm,
    input  logic [31:0] alu_res,
    output logic        ifu_timeout,
    output logic        ifu_fault,
    output logic [1:0]  fsm_state
);

    localparam logic [15:0] TO_LAST = 16'(IMEM_TO - 1);

    ifu_state_e  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic        inst_valid_q, inst_valid_d;
    logic [15:0] to_cnt_q, to_cnt_d;
    logic        run_q;
    logic [31:0] next_pc;
    logic        misaligned;
    logic        to_hit;

    ifu_npc u_npc (
        .pc_i         (pc_q),
        .npc_op_i     (npc_op),
        .imm_i        (imm),
        .alu_res_i    (alu_res),
        .pc_plus4_o   (pc_plus4),
        .next_pc_o    (next_pc),
        .misaligned_o (misaligned)
    );

    assign to_hit = (IMEM_TO != 0) && (to_cnt_q == TO_LAST);

    // Next-state, register updates and handshake outputs
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_d       = inst_q;
        inst_valid_d = inst_valid_q;
        to_cnt_d     = to_cnt_q;
        imem_req     = 1'b0;
        ifu_timeout  = 1'b0;
        case (state_q)
            S_REQ: begin
                // run_q keeps the request low until the first edge after reset
                imem_req = run_q;
                if (run_q && imem_gnt) begin
                    state_d  = S_WAIT;
                    to_cnt_d = '0;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    inst_d       = imem_rdata;
                    inst_valid_d = 1'b1;
                    to_cnt_d     = '0;
                    state_d      = S_HOLD;
                end else if (to_hit) begin
                    ifu_timeout = 1'b1;
                    to_cnt_d    = '0;
                    state_d     = S_REQ;
                end else begin
                    to_cnt_d = to_cnt_q + 16'd1;
                end
            end
            S_HOLD: begin
                if (retire) begin
                    pc_d         = next_pc;
                    inst_valid_d = 1'b0;
                    state_d      = misaligned ? S_FAULT : S_REQ;
                end
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: state_d = S_REQ;
        endcase
    end

    // State, PC/IR and timeout counter registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= S_REQ;
            pc_q         <= RESET_PC;
            inst_q       <= NOP_INST;
            inst_valid_q <= 1'b0;
            to_cnt_q     <= '0;
            run_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            inst_valid_q <= inst_valid_d;
            to_cnt_q     <= to_cnt_d;
            run_q        <= 1'b1;
        end
    end

    assign imem_addr  = pc_q;
    assign pc         = pc_q;
    assign inst       = inst_q;
    assign inst_valid = inst_valid_q;
    assign fsm_state  = state_q;

`ifdef IFU_MISALIGN_TRAP_EN
    assign ifu_fault = (state_q == S_FAULT);
`else
    assign ifu_fault = 1'b0;
`endif

endmodule
